// File: rtl/ast_width_extender.sv
// Avalon-ST width extender: packs N narrow sink words into one wide
// source beat, LSB lane first, with packet framing and empty tracking.
module ast_width_extender #(
    parameter int DATA_IN_W   = 64,
    parameter int DATA_OUT_W  = 256,
    parameter int CHANNEL_W   = 10,
    parameter int EMPTY_IN_W  = $clog2(DATA_IN_W/8),
    parameter int EMPTY_OUT_W = $clog2(DATA_OUT_W/8)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int N        = DATA_OUT_W / DATA_IN_W;
    localparam int IDX_W    = $clog2(N);
    localparam int BYTES_IN = DATA_IN_W / 8;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    // Accumulator side
    logic [DATA_OUT_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   open_q, open_d;
    logic                   first_q, first_d;
    logic [CHANNEL_W-1:0]   chan_q, chan_d;

    // Output register side
    logic [DATA_OUT_W-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [EMPTY_OUT_W-1:0] empty_q, empty_d;
    logic [CHANNEL_W-1:0]   ochan_q, ochan_d;

    // Scratch values for the word being accepted
    logic                   accept;
    logic [IDX_W-1:0]       k;
    logic [DATA_OUT_W-1:0]  lanes;
    logic [CHANNEL_W-1:0]   pkt_chan;
    logic                   pkt_first;
    int                     lane;
    int                     empty_calc;

    assign ast_ready_o = !valid_q || ast_ready_i;
    assign accept      = ast_valid_i && ast_ready_o;

    // Next-state: drain the output register, then merge the accepted word
    always_comb begin
        acc_d      = acc_q;
        idx_d      = idx_q;
        open_d     = open_q;
        first_d    = first_q;
        chan_d     = chan_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        empty_d    = empty_q;
        ochan_d    = ochan_q;
        k          = idx_q;
        lanes      = acc_q;
        pkt_chan   = chan_q;
        pkt_first  = first_q;
        lane       = 0;
        empty_calc = 0;

        if (valid_q && ast_ready_i) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = '0;
        end

        if (accept) begin
            // A start word always restarts at lane 0, dropping any partial beat
            if (ast_startofpacket_i) begin
                k         = '0;
                lanes     = '0;
                pkt_chan  = ast_channel_i;
                pkt_first = 1'b1;
            end
            // Words outside an open packet are swallowed
            if (ast_startofpacket_i || open_q) begin
                lane = int'(k);
                lanes[lane*DATA_IN_W +: DATA_IN_W] = ast_data_i;
                empty_calc = (N - 1 - lane) * BYTES_IN + int'(ast_empty_i);
                if (ast_endofpacket_i || k == LAST) begin
                    valid_d = 1'b1;
                    data_d  = lanes;
                    sop_d   = pkt_first;
                    eop_d   = ast_endofpacket_i;
                    empty_d = ast_endofpacket_i ? EMPTY_OUT_W'(empty_calc) : '0;
                    ochan_d = pkt_chan;
                    acc_d   = '0;
                    idx_d   = '0;
                    open_d  = !ast_endofpacket_i;
                    first_d = 1'b0;
                    chan_d  = pkt_chan;
                end else begin
                    acc_d   = lanes;
                    idx_d   = k + IDX_W'(1);
                    open_d  = 1'b1;
                    first_d = pkt_first;
                    chan_d  = pkt_chan;
                end
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            acc_q   <= '0;
            idx_q   <= '0;
            open_q  <= 1'b0;
            first_q <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            ochan_q <= '0;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            open_q  <= open_d;
            first_q <= first_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            empty_q <= empty_d;
            ochan_q <= ochan_d;
        end
    end

    assign ast_data_o          = data_q;
    assign ast_valid_o         = valid_q;
    assign ast_startofpacket_o = sop_q;
    assign ast_endofpacket_o   = eop_q;
    assign ast_empty_o         = empty_q;
    assign ast_channel_o       = ochan_q;

endmodule

// File: tb/tb_ast_width_extender.sv
// Bench for ast_width_extender: directed packets, expected beats
// queued as a scoreboard and checked when the source transfers.
module tb_ast_width_extender;

    logic         clk_i = 1'b0;
    logic         srst_i;
    logic [63:0]  ast_data_i;
    logic         ast_startofpacket_i;
    logic         ast_endofpacket_i;
    logic         ast_valid_i;
    logic [2:0]   ast_empty_i;
    logic [9:0]   ast_channel_i;
    logic         ast_ready_o;
    logic [255:0] ast_data_o;
    logic         ast_startofpacket_o;
    logic         ast_endofpacket_o;
    logic         ast_valid_o;
    logic [4:0]   ast_empty_o;
    logic [9:0]   ast_channel_o;
    logic         ast_ready_i;

    typedef struct packed {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [4:0]   empty;
        logic [9:0]   chan;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int errors = 0;

    ast_width_extender dut (
        .clk_i               (clk_i),
        .srst_i              (srst_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic expect_beat(input logic [255:0] d, input logic s, e,
                               input logic [4:0] em, input logic [9:0] ch);
        beat_t b;
        b.data  = d;
        b.sop   = s;
        b.eop   = e;
        b.empty = em;
        b.chan  = ch;
        q.push_back(b);
    endtask

    task automatic drive(input logic [63:0] d, input logic s, e,
                         input logic [2:0] em, input logic [9:0] ch);
        ast_data_i          = d;
        ast_startofpacket_i = s;
        ast_endofpacket_i   = e;
        ast_empty_i         = em;
        ast_channel_i       = ch;
        ast_valid_i         = 1'b1;
    endtask

    task automatic send(input logic [63:0] d, input logic s, e,
                        input logic [2:0] em, input logic [9:0] ch);
        int n;
        drive(d, s, e, em, ch);
        n = 0;
        @(negedge clk_i);
        while (!ast_ready_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("send_ready", 256'(ast_ready_o), 256'(1));
        @(posedge clk_i);
        #1;
        ast_valid_i = 1'b0;
    endtask

    // Source-side monitor: every transferred beat must match the queue head
    always @(negedge clk_i) begin
        if (srst_i && ast_valid_o && ast_ready_i) begin
            beat_t e;
            if (q.size() == 0) begin
                chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
                e = q.pop_front();
                chk("beat_data", ast_data_o, e.data);
                chk("beat_sop", 256'(ast_startofpacket_o), 256'(e.sop));
                chk("beat_eop", 256'(ast_endofpacket_o), 256'(e.eop));
                chk("beat_empty", 256'(ast_empty_o), 256'(e.empty));
                chk("beat_chan", 256'(ast_channel_o), 256'(e.chan));
            end
        end
    end

    initial begin
        srst_i              = 1'b0;
        ast_data_i          = '0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
        ast_valid_i         = 1'b0;
        ast_empty_i         = '0;
        ast_channel_i       = '0;
        ast_ready_i         = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 256'(ast_valid_o), 256'(0));
        chk("rst_sop", 256'(ast_startofpacket_o), 256'(0));
        chk("rst_eop", 256'(ast_endofpacket_o), 256'(0));
        chk("rst_data", ast_data_o, 256'(0));
        chk("rst_empty", 256'(ast_empty_o), 256'(0));
        chk("rst_chan", 256'(ast_channel_o), 256'(0));
        chk("rst_ready", 256'(ast_ready_o), 256'(1));
        srst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Full 4-word packet, one cycle latency
        expect_beat(pack4(64'h1, 64'h2, 64'h3, 64'h4), 1, 1, 5'd0, 10'd5);
        send(64'h1, 1, 0, 3'd0, 10'd5);
        send(64'h2, 0, 0, 3'd0, 10'd5);
        send(64'h3, 0, 0, 3'd0, 10'd5);
        chk("pre_valid", 256'(ast_valid_o), 256'(0));
        send(64'h4, 0, 1, 3'd0, 10'd5);
        chk("lat_valid", 256'(ast_valid_o), 256'(1));

        // Six words, partial last beat with empty_i=3
        expect_beat(pack4(64'h11, 64'h12, 64'h13, 64'h14), 1, 0, 5'd0, 10'd7);
        expect_beat(pack4(64'h15, 64'h16, 64'h0, 64'h0), 0, 1, 5'd19, 10'd7);
        send(64'h11, 1, 0, 3'd0, 10'd7);
        send(64'h12, 0, 0, 3'd0, 10'd7);
        send(64'h13, 0, 0, 3'd0, 10'd7);
        send(64'h14, 0, 0, 3'd0, 10'd7);
        send(64'h15, 0, 0, 3'd0, 10'd7);
        send(64'h16, 0, 1, 3'd3, 10'd7);

        // Single-word packet
        expect_beat(256'(64'hAB), 1, 1, 5'd24, 10'd2);
        send(64'hAB, 1, 1, 3'd0, 10'd2);

        // Backpressure with a pending beat and a waiting sink word
        @(posedge clk_i);
        #1;
        ast_ready_i = 1'b0;
        expect_beat(pack4(64'h21, 64'h22, 64'h23, 64'h24), 1, 0, 5'd0, 10'd3);
        expect_beat(pack4(64'h25, 64'h26, 64'h27, 64'h28), 0, 1, 5'd0, 10'd3);
        send(64'h21, 1, 0, 3'd0, 10'd3);
        send(64'h22, 0, 0, 3'd0, 10'd3);
        send(64'h23, 0, 0, 3'd0, 10'd3);
        send(64'h24, 0, 0, 3'd0, 10'd3);
        drive(64'h25, 0, 0, 3'd0, 10'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 256'(ast_ready_o), 256'(0));
            chk("bp_valid", 256'(ast_valid_o), 256'(1));
            chk("bp_data", ast_data_o, pack4(64'h21, 64'h22, 64'h23, 64'h24));
            chk("bp_sop", 256'(ast_startofpacket_o), 256'(1));
            @(posedge clk_i);
            #1;
        end
        ast_ready_i = 1'b1;
        send(64'h25, 0, 0, 3'd0, 10'd3);
        send(64'h26, 0, 0, 3'd0, 10'd3);
        send(64'h27, 0, 0, 3'd0, 10'd3);
        send(64'h28, 0, 1, 3'd0, 10'd3);

        // Reset in the middle of a packet
        repeat (2) @(posedge clk_i);
        #1;
        send(64'h31, 1, 0, 3'd0, 10'd9);
        send(64'h32, 0, 0, 3'd0, 10'd9);
        srst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(ast_valid_o), 256'(0));
        chk("mid_rst_data", ast_data_o, 256'(0));
        chk("mid_rst_chan", 256'(ast_channel_o), 256'(0));
        @(posedge clk_i);
        #1;
        srst_i = 1'b1;
        chk("post_rst_ready", 256'(ast_ready_o), 256'(1));
        send(64'h33, 0, 0, 3'd0, 10'd9);
        expect_beat(pack4(64'h41, 64'h42, 64'h43, 64'h44), 1, 1, 5'd0, 10'd4);
        send(64'h41, 1, 0, 3'd0, 10'd4);
        send(64'h42, 0, 0, 3'd0, 10'd4);
        send(64'h43, 0, 0, 3'd0, 10'd4);
        send(64'h44, 0, 1, 3'd0, 10'd4);

        // Stray word with no open packet, then a packet with empty_i=5
        send(64'h88, 0, 0, 3'd0, 10'd1);
        expect_beat(pack4(64'h51, 64'h52, 64'h53, 64'h54), 1, 1, 5'd5, 10'd1);
        send(64'h51, 1, 0, 3'd0, 10'd1);
        send(64'h52, 0, 0, 3'd0, 10'd1);
        send(64'h53, 0, 0, 3'd0, 10'd1);
        send(64'h54, 0, 1, 3'd5, 10'd1);

        // New start inside an open packet discards the partial beat
        send(64'h61, 1, 0, 3'd0, 10'd8);
        send(64'h62, 0, 0, 3'd0, 10'd8);
        expect_beat(pack4(64'h71, 64'h72, 64'h73, 64'h74), 1, 1, 5'd0, 10'd6);
        send(64'h71, 1, 0, 3'd0, 10'd6);
        send(64'h72, 0, 0, 3'd0, 10'd6);
        send(64'h73, 0, 0, 3'd0, 10'd6);
        send(64'h74, 0, 1, 3'd0, 10'd6);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_empty", 256'(q.size()), 256'(0));
        chk("idle_valid", 256'(ast_valid_o), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
